// File: rtl/branch_history_updater_pkg.sv
// Shared types for the branch history updater: 2-bit counter encodings,
// the saturating update rule and the in-flight FIFO entry layout.
package bhu_pkg;

    localparam int BHU_GHR_WIDTH  = 8;
    localparam int BHU_FIFO_DEPTH = 4;
    localparam int BHU_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    // The entry width is fixed by the package, so GHR_WIDTH on the modules must match it.
    typedef struct packed {
        logic [BHU_GHR_WIDTH-1:0] ghr;
        ctr_e                     ctr;
        logic                     taken;
    } bhu_entry_t;

    function automatic ctr_e sat_update(input ctr_e ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr_e'(ctr + 2'd1);
        end
        return (ctr == SNT) ? SNT : ctr_e'(ctr - 2'd1);
    endfunction

endpackage

// File: rtl/branch_history_updater_if.sv
// Prediction, resolution and PHT-write signals of the branch history updater.
// master = front end / EX side, slave = the updater itself.
interface branch_history_updater_if #(
    parameter int GHR_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
);
    localparam int OCC_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                 pred_valid;
    logic [GHR_WIDTH-1:0] pred_ghr;
    logic [1:0]           pred_ctr;
    logic                 pred_taken;
    logic                 pred_ready;
    logic                 res_valid;
    logic                 res_taken;
    logic                 pht_we;
    logic [GHR_WIDTH-1:0] pht_waddr;
    logic [1:0]           pht_wdata;
    logic                 mispredict;
    logic [GHR_WIDTH-1:0] restore_ghr;
    logic [OCC_WIDTH-1:0] inflight;
    logic                 res_err;
    logic [CNT_WIDTH-1:0] br_count;
    logic [CNT_WIDTH-1:0] mp_count;

    modport master (
        output pred_valid, pred_ghr, pred_ctr, pred_taken, res_valid, res_taken,
        input  pred_ready, pht_we, pht_waddr, pht_wdata, mispredict, restore_ghr,
               inflight, res_err, br_count, mp_count
    );

    modport slave (
        input  pred_valid, pred_ghr, pred_ctr, pred_taken, res_valid, res_taken,
        output pred_ready, pht_we, pht_waddr, pht_wdata, mispredict, restore_ghr,
               inflight, res_err, br_count, mp_count
    );

endinterface

// File: rtl/bhu_inflight_fifo.sv
// In-order FIFO of predicted branches awaiting resolution; clear beats push,
// occupancy is a separate counter so the pointers wrap naturally.
module bhu_inflight_fifo
    import bhu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  bhu_entry_t               wdata_i,
    output bhu_entry_t               rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    bhu_entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W:0]         count_q;
    logic                   pop_ok;
    logic                   push_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && !clear_i && (!full_o || pop_ok);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        end
    end

    // NOTE: storage has no reset; an entry is only read after being written, and the count gates that.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/branch_history_updater.sv
// Training side of the global-history predictor: resolves the oldest in-flight
// branch, writes the saturated PHT counter and flags mispredicts with the restore GHR.
module branch_history_updater
    import bhu_pkg::*;
#(
    parameter int GHR_WIDTH  = BHU_GHR_WIDTH,
    parameter int FIFO_DEPTH = BHU_FIFO_DEPTH,
    parameter int CNT_WIDTH  = BHU_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    branch_history_updater_if.slave  bus
);
    bhu_entry_t                  head;
    bhu_entry_t                  new_entry;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic                        full;
    logic                        empty;
    logic                        resolve;
    logic                        wrong_dir;
    ctr_e                        new_ctr;

    logic                 pht_we_q,      pht_we_d;
    logic [GHR_WIDTH-1:0] pht_waddr_q,   pht_waddr_d;
    logic [1:0]           pht_wdata_q,   pht_wdata_d;
    logic                 mispredict_q,  mispredict_d;
    logic [GHR_WIDTH-1:0] restore_ghr_q, restore_ghr_d;
    logic                 res_err_q,     res_err_d;
    logic [CNT_WIDTH-1:0] br_count_q,    br_count_d;
    logic [CNT_WIDTH-1:0] mp_count_q,    mp_count_d;

    assign resolve   = bus.res_valid && !empty;
    assign wrong_dir = bus.res_taken != head.taken;
    assign new_ctr   = sat_update(head.ctr, bus.res_taken);
    assign new_entry = '{ghr: bus.pred_ghr, ctr: ctr_e'(bus.pred_ctr), taken: bus.pred_taken};

    // A mispredict clears the FIFO, which also drops any same-cycle (wrong-path) push.
    bhu_inflight_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.pred_valid),
        .pop_i   (resolve && !wrong_dir),
        .clear_i (resolve && wrong_dir),
        .wdata_i (new_entry),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pht_we_d      = 1'b0;
        mispredict_d  = 1'b0;
        pht_waddr_d   = pht_waddr_q;
        pht_wdata_d   = pht_wdata_q;
        restore_ghr_d = restore_ghr_q;
        br_count_d    = br_count_q;
        mp_count_d    = mp_count_q;
        res_err_d     = res_err_q || (bus.res_valid && empty);
        if (resolve) begin
            pht_we_d      = (new_ctr != head.ctr);
            pht_waddr_d   = head.ghr;
            pht_wdata_d   = new_ctr;
            mispredict_d  = wrong_dir;
            restore_ghr_d = {bus.res_taken, head.ghr[GHR_WIDTH-1:1]};
            br_count_d    = br_count_q + CNT_WIDTH'(1);
            if (wrong_dir) mp_count_d = mp_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pht_we_q      <= 1'b0;
            pht_waddr_q   <= '0;
            pht_wdata_q   <= '0;
            mispredict_q  <= 1'b0;
            restore_ghr_q <= '0;
            res_err_q     <= 1'b0;
            br_count_q    <= '0;
            mp_count_q    <= '0;
        end else begin
            pht_we_q      <= pht_we_d;
            pht_waddr_q   <= pht_waddr_d;
            pht_wdata_q   <= pht_wdata_d;
            mispredict_q  <= mispredict_d;
            restore_ghr_q <= restore_ghr_d;
            res_err_q     <= res_err_d;
            br_count_q    <= br_count_d;
            mp_count_q    <= mp_count_d;
        end
    end

    assign bus.pred_ready  = !full;
    assign bus.inflight    = count;
    assign bus.pht_we      = pht_we_q;
    assign bus.pht_waddr   = pht_waddr_q;
    assign bus.pht_wdata   = pht_wdata_q;
    assign bus.mispredict  = mispredict_q;
    assign bus.restore_ghr = restore_ghr_q;
    assign bus.res_err     = res_err_q;
    assign bus.br_count    = br_count_q;
    assign bus.mp_count    = mp_count_q;

endmodule

// File: tb/tb_branch_history_updater.sv
// Directed bench for branch_history_updater: hand-computed expectations checked
// with immediate assertions one cycle after each stimulus edge.
module tb_branch_history_updater;
    import bhu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    branch_history_updater_if #(.GHR_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(16)) bus ();

    branch_history_updater #(.GHR_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] g, input ctr_e c, input logic t);
        bus.pred_valid = 1'b1;
        bus.pred_ghr   = g;
        bus.pred_ctr   = c;
        bus.pred_taken = t;
        step();
        bus.pred_valid = 1'b0;
    endtask

    task automatic resolve(input logic t);
        bus.res_valid = 1'b1;
        bus.res_taken = t;
        step();
        bus.res_valid = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic we, input logic [7:0] addr,
                               input logic [1:0] data, input logic mp);
        check({tag, ".pht_we"},     32'(bus.pht_we),     32'(we));
        check({tag, ".pht_waddr"},  32'(bus.pht_waddr),  32'(addr));
        check({tag, ".pht_wdata"},  32'(bus.pht_wdata),  32'(data));
        check({tag, ".mispredict"}, 32'(bus.mispredict), 32'(mp));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".pred_ready"},  32'(bus.pred_ready),  1);
        check({tag, ".inflight"},    32'(bus.inflight),    0);
        check({tag, ".pht_we"},      32'(bus.pht_we),      0);
        check({tag, ".mispredict"},  32'(bus.mispredict),  0);
        check({tag, ".res_err"},     32'(bus.res_err),     0);
        check({tag, ".pht_waddr"},   32'(bus.pht_waddr),   0);
        check({tag, ".pht_wdata"},   32'(bus.pht_wdata),   0);
        check({tag, ".restore_ghr"}, 32'(bus.restore_ghr), 0);
        check({tag, ".br_count"},    32'(bus.br_count),    0);
        check({tag, ".mp_count"},    32'(bus.mp_count),    0);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.pred_valid = 1'b0;
        bus.pred_ghr   = '0;
        bus.pred_ctr   = '0;
        bus.pred_taken = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_taken  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check_reset_state("reset");

        // Weakly-not-taken branch actually taken: counter rises, mispredict.
        push(8'h00, WNT, 1'b0);
        check("t1.inflight", 32'(bus.inflight), 1);
        resolve(1'b1);
        check_write("t1", 1'b1, 8'h00, WT, 1'b1);
        check("t1.restore_ghr", 32'(bus.restore_ghr), 'h80);
        check("t1.mp_count",    32'(bus.mp_count),    1);
        check("t1.br_count",    32'(bus.br_count),    1);
        check("t1.inflight",    32'(bus.inflight),    0);
        step();
        check("t1.we_pulse", 32'(bus.pht_we),     0);
        check("t1.mp_pulse", 32'(bus.mispredict), 0);

        // Saturated strongly-taken, correct: no write but address/data still update.
        push(8'hA5, ST, 1'b1);
        resolve(1'b1);
        check_write("t2", 1'b0, 8'hA5, ST, 1'b0);
        check("t2.restore_ghr", 32'(bus.restore_ghr), 'hD2);
        check("t2.br_count",    32'(bus.br_count),    2);
        check("t2.mp_count",    32'(bus.mp_count),    1);

        // Fill the FIFO; a fifth push is ignored.
        push(8'h10, WT,  1'b1);
        push(8'h20, WNT, 1'b0);
        push(8'h30, SNT, 1'b0);
        push(8'h40, ST,  1'b1);
        check("t3.inflight_full", 32'(bus.inflight),   4);
        check("t3.ready_full",    32'(bus.pred_ready), 0);
        push(8'h50, WT, 1'b1);
        check("t3.push_ignored", 32'(bus.inflight), 4);
        check("t3.no_err",       32'(bus.res_err),  0);

        // Correct resolve of the head with a simultaneous push while full.
        bus.pred_valid = 1'b1;
        bus.pred_ghr   = 8'h60;
        bus.pred_ctr   = WT;
        bus.pred_taken = 1'b1;
        check("t3.ready_low_sim", 32'(bus.pred_ready), 0);
        resolve(1'b1);
        bus.pred_valid = 1'b0;
        check_write("t3.h10", 1'b1, 8'h10, ST, 1'b0);
        check("t3.inflight_sim", 32'(bus.inflight), 4);
        check("t3.br_count",     32'(bus.br_count), 3);

        // Drain in order: 20, 30, 40, then the pushed 60 (50 never entered).
        resolve(1'b0);
        check_write("t3.h20", 1'b1, 8'h20, SNT, 1'b0);
        resolve(1'b0);
        check_write("t3.h30", 1'b0, 8'h30, SNT, 1'b0);
        resolve(1'b1);
        check_write("t3.h40", 1'b0, 8'h40, ST, 1'b0);
        resolve(1'b0);
        check_write("t3.h60", 1'b1, 8'h60, WNT, 1'b1);
        check("t3.restore_ghr", 32'(bus.restore_ghr), 'h30);
        check("t3.br_count",    32'(bus.br_count),    7);
        check("t3.mp_count",    32'(bus.mp_count),    2);
        check("t3.drained",     32'(bus.inflight),    0);

        // Mispredict on the head flushes younger entries and the same-cycle push.
        push(8'h11, WT, 1'b1);
        push(8'h22, WT, 1'b1);
        push(8'h33, WT, 1'b1);
        bus.pred_valid = 1'b1;
        bus.pred_ghr   = 8'h44;
        bus.pred_ctr   = WT;
        bus.pred_taken = 1'b1;
        resolve(1'b0);
        bus.pred_valid = 1'b0;
        check_write("t4", 1'b1, 8'h11, WNT, 1'b1);
        check("t4.restore_ghr", 32'(bus.restore_ghr), 'h08);
        check("t4.inflight",    32'(bus.inflight),    0);
        check("t4.mp_count",    32'(bus.mp_count),    3);
        check("t4.br_count",    32'(bus.br_count),    8);
        step();
        check("t4.idle_we", 32'(bus.pht_we), 0);

        // Resolve with nothing in flight: sticky error, nothing else moves.
        resolve(1'b1);
        check("t5.res_err",  32'(bus.res_err),   1);
        check("t5.no_we",    32'(bus.pht_we),    0);
        check("t5.br_count", 32'(bus.br_count),  8);
        check("t5.waddr",    32'(bus.pht_waddr), 'h11);
        step();
        step();
        check("t5.sticky", 32'(bus.res_err), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_state("t5.reset");

        // Reset with two branches in flight discards them.
        push(8'h77, WT,  1'b1);
        push(8'h88, WNT, 1'b0);
        check("t6.inflight_2", 32'(bus.inflight), 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6.inflight_0", 32'(bus.inflight),   0);
        check("t6.ready",      32'(bus.pred_ready), 1);
        resolve(1'b1);
        check("t6.no_we",      32'(bus.pht_we),   0);
        check("t6.br_count",   32'(bus.br_count), 0);
        check("t6.res_err",    32'(bus.res_err),  1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_history_updater.md
Name: branch_history_updater

Overview:
- Training/write side of the global-history branch predictor.
- Tracks in-flight predicted branches in order, in a small FIFO. Each entry holds the GHR snapshot, predicted direction and 2-bit counter value captured at prediction time.
- When EX resolves the oldest branch, the block computes the saturated counter update and drives the PHT write port.
- On a direction mismatch it flags a mispredict and supplies the corrected GHR for restore.

Parameters:
- GHR_WIDTH, 8, global history length; also the PHT index width.
- FIFO_DEPTH, 4, maximum in-flight unresolved branches; power of two, at least 2.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- pred_valid  in  1  fetch issued a predicted branch this cycle
- pred_ghr  in  GHR_WIDTH  GHR value used to index the PHT for this branch
- pred_ctr  in  2  PHT counter read at that index
- pred_taken  in  1  predicted direction (equals pred_ctr[1])
- pred_ready  out  1  FIFO not full; fetch stalls branches while low
- res_valid  in  1  EX resolved the oldest in-flight branch
- res_taken  in  1  actual direction
- pht_we  out  1  PHT write strobe, one-cycle pulse
- pht_waddr  out  GHR_WIDTH  PHT write index
- pht_wdata  out  2  new counter value
- mispredict  out  1  one-cycle pulse; front end flushes and restores GHR
- restore_ghr  out  GHR_WIDTH  corrected history {res_taken, snapshot[GHR_WIDTH-1:1]}; valid while mispredict is high
- inflight  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- res_err  out  1  sticky: res_valid arrived while the FIFO was empty
- br_count  out  CNT_WIDTH  branches resolved; wraps
- mp_count  out  CNT_WIDTH  mispredicts; wraps

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO empty; pred_ready=1.
  - pht_we=0, mispredict=0, res_err=0.
  - pht_waddr=0, pht_wdata=0, restore_ghr=0, br_count=0, mp_count=0.
- Reset mid-operation discards all in-flight entries. No PHT write is issued for them.
- Push: at the edge where pred_valid=1 and pred_ready=1, write {pred_ghr, pred_ctr, pred_taken} at the tail.
- pred_valid=1 while full: the push is ignored. Occupancy is unchanged; no error is raised.
- Resolve: at the edge where res_valid=1 and the FIFO is non-empty, pop the head entry (ghr, ctr, ptaken) and register these outputs, all visible the following cycle (latency 1):
  - Counter update:
    - res_taken=1: new = (ctr==3) ? 3 : ctr+1
    - res_taken=0: new = (ctr==0) ? 0 : ctr-1
  - pht_we = (new != ctr). A saturated counter that does not change issues no write.
  - pht_waddr = ghr; pht_wdata = new. Both are updated on every resolve, even when pht_we=0.
  - mispredict = (res_taken != ptaken); restore_ghr updated on every resolve.
  - br_count += 1; mp_count += 1 when mispredicting.
- Mispredict flush:
  - At the resolving edge, all younger entries are discarded: FIFO cleared, occupancy 0.
  - A push presented in the same cycle is dropped (wrong path).
- Correct prediction with a push in the same cycle: pop and push both occur; occupancy is unchanged. This is legal when full, and pred_ready stays 0 that cycle (computed from registered occupancy).
- res_valid=1 while empty: res_err set and held until reset. No pop, no write, no counter change.
- Every output is a register. No combinational path from any input to any output except pred_ready, which depends only on registered occupancy.
- Pointers are log2(FIFO_DEPTH) bits with natural wrap-around; occupancy is kept as a separate counter.

Decomposition:
- Package bhu_pkg:
  - counter encodings SNT=2'd0, WNT=2'd1, WT=2'd2, ST=2'd3
  - a function sat_update(ctr, taken) returning the new 2-bit counter
  - the FIFO entry struct {ghr, ctr, taken}
- Sub-module bhu_inflight_fifo: synchronous FIFO with push, pop and clear, where clear has priority over push. Instantiated once.

Test Plan:
- Reset, then push ghr=8'h00, ctr=WNT, taken=0; resolve taken=1 → next cycle pht_we=1, waddr=0x00, wdata=WT, mispredict=1, restore_ghr=8'h80, mp_count=1.
- Push ghr=8'hA5, ctr=ST, taken=1; resolve taken=1 → pht_we=0, wdata=ST, mispredict=0, br_count increments.
- Push 4 entries → pred_ready=0 and a 5th push is ignored. Resolve the head correctly with a simultaneous push → inflight stays 4, FIFO order preserved.
- Push 3 entries; resolve the first as a mispredict while pred_valid=1 → inflight=0 next cycle, the dropped push never resolves, and the remaining entries produce no writes.
- Drive res_valid with an empty FIFO → res_err=1 and sticky; no pht_we. Assert rst_n=0 for one edge → res_err=0 and all outputs at reset values.
- Assert rst_n=0 while 2 entries are in flight → inflight=0, pred_ready=1, and no pht_we afterwards for those entries.
